mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port synchronous RAM (registered read) between the fetch port and the
//   load/store port of the pipelined core. Fetch and data requesters each see a req/gnt
//   handshake plus a tagged read-return path. The block replaces the separate I$/D$ instances
//   with a unified memory and produces the pipeline stall condition.
// PARAMETERS
//   ADDR_W        12  word-address width driven to RAM (byte addr bits [ADDR_W+1:2])
//   DATA_W        32  data width of all data buses
//   RD_LAT        1   RAM read latency in clk cycles, legal 1..4
//   MAX_D_STREAK  3   max consecutive data grants while a fetch waits, legal 1..15
// PORTS
//   clk        in   1       core clock; all state updates on rising edge
//   rst        in   1       asynchronous, active-high reset
//   if_req     in   1       fetch read request; hold with if_addr stable until if_gnt
//   if_addr    in   32      fetch byte address; bits [1:0] ignored
//   if_flush   in   1       discard all in-flight fetch returns (branch/jump redirect)
//   if_gnt     out  1       fetch accepted this cycle (comb.)
//   if_rvalid  out  1       fetch read data valid on if_rdata
//   if_rdata   out  DATA_W  fetch read data
//   d_req      in   1       data request; hold with d_we/d_addr/d_wdata stable until d_gnt
//   d_we       in   1       1 = store, 0 = load
//   d_addr     in   32      data byte address; bits [1:0] ignored
//   d_wdata    in   DATA_W  store data
//   d_gnt      out  1       data access accepted this cycle (comb.)
//   d_rvalid   out  1       load data valid on d_rdata
//   d_rdata    out  DATA_W  load data
//   mem_addr   out  ADDR_W  RAM word address
//   mem_wdata  out  DATA_W  RAM write data
//   mem_wren   out  1       RAM write enable
//   mem_q      in   DATA_W  RAM read data, RD_LAT cycles after address
//   stall      out  1       (if_req & ~if_gnt) | (d_req & ~d_gnt)
// BEHAVIOUR
//   - Transfer occurs when req & gnt are both high in a cycle; at most one gnt per cycle.
//   - Arbitration (comb.): only one requester -> grant it. Both -> data wins unless
//     streak == MAX_D_STREAK, in which case fetch wins.
//   - streak (4-bit reg): +1 on a data grant while if_req is high and not granted.
//     Cleared on any fetch grant or any cycle with if_req low. Saturates at MAX_D_STREAK.
//   - Granted cycle: mem_addr = granted addr[ADDR_W+1:2]. mem_wren = d_gnt & d_we.
//     mem_wdata = d_wdata. With no grant: mem_addr = 0, mem_wren = 0.
//   - Stores: complete at grant. No d_rvalid is produced.
//   - Reads: the grant pushes tag {valid, src} into an RD_LAT-deep shift pipeline.
//     if_rvalid/d_rvalid pulse exactly RD_LAT cycles after the grant cycle. Both rdata
//     buses = mem_q and are meaningful only while the matching rvalid is high.
//   - Back-to-back grants are legal every cycle. Returns stay in grant order, one per cycle.
//   - if_flush: clears valid on every in-flight fetch tag, including a fetch granted in the
//     same cycle. Data tags are unaffected. Arbitration is unaffected.
//   - Store followed by load to the same address: the load returns the new data (RAM
//     write-then-read ordering across cycles).
//   - Reset (async, any time): streak = 0 and all tags invalid. if_gnt, d_gnt, mem_wren,
//     if_rvalid, d_rvalid, stall = 0 while rst is high. mem_addr = 0.
//     In-flight reads at reset never return.
//   - No gnt is issued in a cycle where rst is high. The first grant is possible in the
//     first cycle after rst deasserts.
// TESTING
//   1. Fetch only, RD_LAT=1, if_addr=0x10 held 1 cycle -> if_gnt=1, mem_addr=4;
//      next cycle if_rvalid=1, if_rdata=RAM[4]
//   2. Store d_addr=0x20 d_wdata=0xDEADBEEF, then load 0x20 -> mem_wren=1 once;
//      load d_rvalid=1 with 0xDEADBEEF; no d_rvalid for the store
//   3. if_req and d_req both high 8 cycles, MAX_D_STREAK=3 -> grant sequence D,D,D,F,D,D,D,F;
//      stall=1 every cycle
//   4. RD_LAT=3, fetch grants at cycles 0,1, if_flush at cycle 2 -> no if_rvalid at cycles 3,4;
//      a data load granted at cycle 1 instead still returns at cycle 4
//   5. rst pulsed while 2 loads are in flight (RD_LAT=2) -> d_rvalid never asserts;
//      all outputs 0 during rst; fresh load after release returns after 2 cycles
//   6. Misaligned d_addr=0x23 load -> mem_addr=8, same data as 0x20

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store traffic onto one registered-read RAM and tags read returns
// so they come back on the right port RD_LAT cycles after the grant.
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int MAX_D_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              stall
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    logic [3:0]        streak_q, streak_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_src_q, tag_src_d;
    logic              fetch_prio;

    // Data wins a collision until it has starved fetch MAX_D_STREAK times in a row.
    assign fetch_prio = (streak_q == STREAK_MAX);
    assign if_gnt     = ~rst & if_req & (~d_req | fetch_prio);
    assign d_gnt      = ~rst & d_req & ~(if_req & fetch_prio);
    assign stall      = ~rst & ((if_req & ~if_gnt) | (d_req & ~d_gnt));

    assign mem_wren   = d_gnt & d_we;
    assign mem_wdata  = d_wdata;

    always_comb begin
        mem_addr = '0;
        if (if_gnt) begin
            mem_addr = if_addr[ADDR_W+1:2];
        end else if (d_gnt) begin
            mem_addr = d_addr[ADDR_W+1:2];
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!if_req || if_gnt) begin
            streak_d = '0;
        end else if (d_gnt && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // Tag pipeline: src=1 marks a fetch; flush kills fetch tags as they shift.
    always_comb begin
        tag_vld_d    = '0;
        tag_src_d    = '0;
        tag_vld_d[0] = (if_gnt & ~if_flush) | (d_gnt & ~d_we);
        tag_src_d[0] = if_gnt;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1] & ~(if_flush & tag_src_q[i-1]);
            tag_src_d[i] = tag_src_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q  <= '0;
            tag_vld_q <= '0;
            tag_src_q <= '0;
        end else begin
            streak_q  <= streak_d;
            tag_vld_q <= tag_vld_d;
            tag_src_q <= tag_src_d;
        end
    end

    // A fetch returning in the flush cycle is also dropped.
    assign if_rvalid = tag_vld_q[RD_LAT-1] & tag_src_q[RD_LAT-1] & ~if_flush;
    assign d_rvalid  = tag_vld_q[RD_LAT-1] & ~tag_src_q[RD_LAT-1];
    assign if_rdata  = mem_q;
    assign d_rdata   = mem_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (RD_LAT 1,2,3) share stimulus; a due-cycle
// scoreboard checks every read return on every instance.
module tb_mem_port_arbiter;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;

    logic [NI-1:0] if_gnt_w, d_gnt_w, mem_wren_w, stall_w, if_rv, d_rv;
    logic [11:0]   maddr  [NI];
    logic [31:0]   mwdata [NI];
    logic [31:0]   rd_if  [NI];
    logic [31:0]   rd_d   [NI];
    logic [31:0]   mq     [NI];

    int cyc = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;

    typedef struct {
        int          idx;
        int          due;
        bit          src;
        logic [31:0] data;
    } ret_t;
    ret_t sb[$];

    logic [31:0] exp_mem [int];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int w);
        return 32'hC0DE_0000 ^ (32'(w) * 32'h0000_9E37);
    endfunction

    // RAM environment model
    bit          ram_vld [0:4095];
    logic [31:0] ram     [0:4095];

    always @(posedge clk) begin
        if (mem_wren_w[0]) begin
            ram[maddr[0]]     <= mwdata[0];
            ram_vld[maddr[0]] <= 1'b1;
        end
    end

    function automatic logic [31:0] ram_rd(logic [11:0] a);
        return ram_vld[a] ? ram[a] : init_val(int'(a));
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gi
        logic [31:0] pipe [0:3];
        always @(posedge clk) begin
            pipe[0] <= ram_rd(maddr[g]);
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
        end
        assign mq[g] = pipe[g];

        mem_port_arbiter #(
            .ADDR_W(12), .DATA_W(32), .RD_LAT(g + 1), .MAX_D_STREAK(3)
        ) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
            .if_gnt(if_gnt_w[g]), .if_rvalid(if_rv[g]), .if_rdata(rd_if[g]),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_gnt(d_gnt_w[g]), .d_rvalid(d_rv[g]), .d_rdata(rd_d[g]),
            .mem_addr(maddr[g]), .mem_wdata(mwdata[g]), .mem_wren(mem_wren_w[g]),
            .mem_q(mq[g]), .stall(stall_w[g])
        );
    end

    function automatic logic [31:0] exp_rd(int w);
        return exp_mem.exists(w) ? exp_mem[w] : init_val(w);
    endfunction

    task automatic push_ret(bit src, int w);
        ret_t r;
        for (int k = 0; k < NI; k++) begin
            r.idx  = k;
            r.due  = cyc + k + 1;
            r.src  = src;
            r.data = exp_rd(w);
            sb.push_back(r);
        end
    endtask

    // Scoreboard pop/compare, run at the falling edge of each cycle.
    task automatic sb_check();
        ret_t r;
        bit   found;
        if (rst) begin
            sb.delete();
            for (int k = 0; k < NI; k++) begin
                chk_cnt++;
                if ({if_gnt_w[k], d_gnt_w[k], mem_wren_w[k], stall_w[k], if_rv[k], d_rv[k]} !== 6'b0
                    || maddr[k] !== 12'h0)
                    $display("FAIL rst_outputs inst%0d cyc%0d got gnt=%b%b wren=%b stall=%b rv=%b%b addr=%h want all 0",
                             k, cyc, if_gnt_w[k], d_gnt_w[k], mem_wren_w[k], stall_w[k], if_rv[k], d_rv[k], maddr[k]);
                else pass_cnt++;
            end
            return;
        end
        if (if_flush) begin
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].src && sb[i].due >= cyc) sb.delete(i);
        end
        for (int k = 0; k < NI; k++) begin
            found = 1'b0;
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].idx == k && sb[i].due == cyc) begin
                    r = sb[i];
                    sb.delete(i);
                    found = 1'b1;
                    break;
                end
            end
            if (found || if_rv[k] || d_rv[k]) begin
                chk_cnt++;
                if (!found)
                    $display("FAIL unexpected_rvalid inst%0d cyc%0d got if_rv=%b d_rv=%b want none",
                             k, cyc, if_rv[k], d_rv[k]);
                else if (if_rv[k] !== r.src || d_rv[k] !== !r.src
                         || (r.src ? rd_if[k] : rd_d[k]) !== r.data)
                    $display("FAIL return inst%0d cyc%0d got if_rv=%b d_rv=%b if=%h d=%h want src=%b data=%h",
                             k, cyc, if_rv[k], d_rv[k], rd_if[k], rd_d[k], r.src, r.data);
                else pass_cnt++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sb_check();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(int n);
        if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0; d_we = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        if_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'h1; if_flush = 1'b0;
        #2;
        chk_cnt++;
        if ({if_gnt_w[0], d_gnt_w[0], mem_wren_w[0], stall_w[0], if_rv[0], d_rv[0]} !== 6'b0 || maddr[0] !== 12'h0)
            $display("FAIL reset_state got gnt=%b%b wren=%b stall=%b addr=%h want 0",
                     if_gnt_w[0], d_gnt_w[0], mem_wren_w[0], stall_w[0], maddr[0]);
        else pass_cnt++;
        step(); step();
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk_cnt++;
        if (if_gnt_w[0] !== 1'b1 || d_gnt_w[0] !== 1'b0 || maddr[0] !== 12'd4 || stall_w[0] !== 1'b0)
            $display("FAIL fetch_grant got gnt=%b d=%b addr=%h stall=%b want 1 0 004 0",
                     if_gnt_w[0], d_gnt_w[0], maddr[0], stall_w[0]);
        else pass_cnt++;
        push_ret(1'b1, 4);
        step();
        if_req = 1'b0;
        #1;
        chk_cnt++;
        if (if_gnt_w[0] !== 1'b0 || maddr[0] !== 12'h0)
            $display("FAIL idle_addr got gnt=%b addr=%h want 0 000", if_gnt_w[0], maddr[0]);
        else pass_cnt++;
        idle(4);
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
        exp_mem[8] = 32'hDEAD_BEEF;
        #1;
        chk_cnt++;
        if (d_gnt_w[0] !== 1'b1 || mem_wren_w[0] !== 1'b1 || maddr[0] !== 12'd8 || mwdata[0] !== 32'hDEAD_BEEF)
            $display("FAIL store got gnt=%b wren=%b addr=%h wdata=%h want 1 1 008 deadbeef",
                     d_gnt_w[0], mem_wren_w[0], maddr[0], mwdata[0]);
        else pass_cnt++;
        step();
        d_we = 1'b0;
        #1;
        chk_cnt++;
        if (d_gnt_w[0] !== 1'b1 || mem_wren_w[0] !== 1'b0 || maddr[0] !== 12'd8)
            $display("FAIL load_after_store got gnt=%b wren=%b addr=%h want 1 0 008",
                     d_gnt_w[0], mem_wren_w[0], maddr[0]);
        else pass_cnt++;
        push_ret(1'b0, 8);
        step();
        idle(4);
    endtask

    task automatic test_misaligned();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h23;
        #1;
        chk_cnt++;
        if (d_gnt_w[0] !== 1'b1 || maddr[0] !== 12'd8)
            $display("FAIL misaligned got gnt=%b addr=%h want 1 008", d_gnt_w[0], maddr[0]);
        else pass_cnt++;
        push_ret(1'b0, 8);
        step();
        idle(4);
    endtask

    task automatic test_arbitration();
        logic [7:0] pat;
        logic [5:0] ireq;
        logic [5:0] pat2;
        pat  = 8'b1000_1000;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
        exp_mem[32] = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk_cnt++;
            if (if_gnt_w[0] !== pat[i] || d_gnt_w[0] !== !pat[i] || stall_w[0] !== 1'b1)
                $display("FAIL arb_seq%0d got f=%b d=%b stall=%b want f=%b d=%b stall=1",
                         i, if_gnt_w[0], d_gnt_w[0], stall_w[0], pat[i], !pat[i]);
            else pass_cnt++;
            if (pat[i]) push_ret(1'b1, 16);
            step();
        end
        // Dropping if_req for a cycle restarts the streak.
        ireq = 6'b111101;
        pat2 = 6'b100000;
        for (int i = 0; i < 6; i++) begin
            if_req = ireq[i];
            #1;
            chk_cnt++;
            if (if_gnt_w[0] !== pat2[i] || d_gnt_w[0] !== !pat2[i])
                $display("FAIL streak_clear%0d got f=%b d=%b want f=%b d=%b",
                         i, if_gnt_w[0], d_gnt_w[0], pat2[i], !pat2[i]);
            else pass_cnt++;
            if (pat2[i]) push_ret(1'b1, 16);
            step();
        end
        idle(5);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [6];
        addrs = '{32'h300, 32'h304, 32'h308, 32'h80, 32'h30C, 32'h20};
        for (int i = 0; i < 6; i++) begin
            if_req = (i % 2 == 0); d_req = (i % 2 == 1); d_we = 1'b0;
            if_addr = addrs[i]; d_addr = addrs[i];
            #1;
            chk_cnt++;
            if (if_gnt_w[0] !== (i % 2 == 0) || d_gnt_w[0] !== (i % 2 == 1) || maddr[0] !== addrs[i][13:2])
                $display("FAIL b2b%0d got f=%b d=%b addr=%h want addr=%h",
                         i, if_gnt_w[0], d_gnt_w[0], maddr[0], addrs[i][13:2]);
            else pass_cnt++;
            push_ret(i % 2 == 0, int'(addrs[i][13:2]));
            step();
        end
        idle(5);
    endtask

    task automatic test_flush();
        for (int r = 0; r < 2; r++) begin
            if_req = 1'b1; if_addr = 32'h400 + 32'(r * 16);
            push_ret(1'b1, int'(if_addr[13:2]));
            step();
            if (r == 0) begin
                if_addr = 32'h404;
                push_ret(1'b1, int'(if_addr[13:2]));
            end else begin
                if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
                push_ret(1'b0, 8);
            end
            step();
            d_req = 1'b0; if_flush = 1'b1;
            if_req = (r == 0); if_addr = 32'h408;
            #1;
            chk_cnt++;
            if (if_gnt_w[0] !== (r == 0))
                $display("FAIL flush_arb%0d got f=%b want %b", r, if_gnt_w[0], r == 0);
            else pass_cnt++;
            if (r == 0) push_ret(1'b1, int'(if_addr[13:2]));
            step();
            idle(6);
        end
    endtask

    task automatic test_reset_inflight();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        push_ret(1'b0, 8);
        step();
        d_addr = 32'h80;
        push_ret(1'b0, 32);
        step();
        d_req = 1'b0; rst = 1'b1;
        step(); step();
        rst = 1'b0; d_req = 1'b1; d_addr = 32'h23;
        #1;
        chk_cnt++;
        if (d_gnt_w[0] !== 1'b1 || maddr[0] !== 12'd8)
            $display("FAIL post_reset_grant got gnt=%b addr=%h want 1 008", d_gnt_w[0], maddr[0]);
        else pass_cnt++;
        push_ret(1'b0, 8);
        step();
        idle(6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_misaligned();
        test_arbitration();
        test_back_to_back();
        test_flush();
        test_reset_inflight();
        chk_cnt++;
        if (sb.size() !== 0)
            $display("FAIL drain got %0d pending returns want 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
